mem_responder: RTL and testbench

Memory-side responder for the CPU's load-strobe interface. The control FSM drives MAR/MDR load strobes and the read/write select; this block services them. It holds the MAR and MDR registers and a single-port storage array, and inserts a programmable number of wait states before each transfer. It signals completion with a one-cycle done pulse, so the sequencer can wait on the memory instead of relying on fixed state counts.

---
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU load-strobe interface.
// Holds MAR/MDR, a single-port storage array, and a wait-state sequencer
// that reports each completed transfer with a one-cycle done pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a transfer request; MAR may be loaded
// S_WAIT | counting wait states down in cnt; the access fires at cnt == 0
// S_DONE | transfer complete, o_done high for this one cycle
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ld_mar,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_ld_mdr,
    input  logic              i_mem_rw,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [ADDR_W-1:0] o_mar,
    output logic [DATA_W-1:0] o_mdr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int        DEPTH    = 1 << ADDR_W;
    localparam bit        NO_WAIT  = (WAIT_CYCLES == 0);
    // Down-counter start value; the access fires when it reaches zero, so
    // loading WAIT_CYCLES-1 yields exactly WAIT_CYCLES wait edges.
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              busy;
    logic              done;
    logic              err;

    // Transfer parameters captured at accept, used by the deferred access.
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_rw;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              strobe;
    logic [ADDR_W-1:0] eff_addr;
    logic              acc_now;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_rw;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] acc_mdr;
    logic              mem_we;

    // Decide whether an access fires this cycle and with which address/data.
    // In S_IDLE the access (zero-wait build only) uses the live inputs;
    // otherwise it uses the values latched at accept.
    always_comb begin
        accept    = (state == S_IDLE) && i_ld_mdr;
        strobe    = i_ld_mar || i_ld_mdr;
        eff_addr  = i_ld_mar ? i_addr : mar;
        acc_now   = 1'b0;
        acc_addr  = lat_addr;
        acc_rw    = lat_rw;
        acc_wdata = lat_wdata;
        if (state == S_IDLE) begin
            acc_addr  = eff_addr;
            acc_rw    = i_mem_rw;
            acc_wdata = i_wdata;
            acc_now   = accept && NO_WAIT;
        end else if (state == S_WAIT) begin
            acc_now   = (cnt == 4'd0);
        end
        rd_data = mem[acc_addr];
        // Write-through: MDR always ends up holding the transferred word.
        acc_mdr = acc_rw ? acc_wdata : rd_data;
        // Gating with reset keeps a write from landing on an edge that
        // occurs while reset is held.
        mem_we  = acc_now && acc_rw && i_rst_n;
    end

    // Storage array: deliberately not reset so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Control FSM with registered busy/done/err and MAR/MDR registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            mar       <= '0;
            mdr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_ld_mar) begin
                        mar <= i_addr;
                    end
                    if (accept) begin
                        lat_addr  <= eff_addr;
                        lat_rw    <= i_mem_rw;
                        lat_wdata <= i_wdata;
                        busy      <= 1'b1;
                        if (NO_WAIT) begin
                            mdr   <= acc_mdr;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (strobe) begin
                        err <= 1'b1;
                    end
                    if (cnt == 4'd0) begin
                        mdr   <= acc_mdr;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (strobe) begin
                        err <= 1'b1;
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mar  = mar;
    assign o_mdr  = mdr;
    assign o_busy = busy;
    assign o_done = done;
    assign o_err  = err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a
// zero-wait instance sharing clock and reset.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       ld_mar = 1'b0, ld_mdr = 1'b0, mem_rw = 1'b0;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic [7:0] mar, mdr;
    logic       busy, done, err;

    logic       ld_mar0 = 1'b0, ld_mdr0 = 1'b0, mem_rw0 = 1'b0;
    logic [7:0] addr0 = 8'h00, wdata0 = 8'h00;
    logic [7:0] mar0, mdr0;
    logic       busy0, done0, err0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ld_mar(ld_mar), .i_addr(addr),
        .i_ld_mdr(ld_mdr), .i_mem_rw(mem_rw), .i_wdata(wdata),
        .o_mar(mar), .o_mdr(mdr), .o_busy(busy), .o_done(done), .o_err(err)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ld_mar(ld_mar0), .i_addr(addr0),
        .i_ld_mdr(ld_mdr0), .i_mem_rw(mem_rw0), .i_wdata(wdata0),
        .o_mar(mar0), .o_mdr(mdr0), .o_busy(busy0), .o_done(done0), .o_err(err0)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transfer with MAR loaded in the same cycle; observes six cycles
    // after the accept edge, collecting busy/done statistics.
    task automatic xfer(input bit sel, input logic rw, input logic [7:0] a,
                        input logic [7:0] wd, output int busy_n,
                        output int done_n, output int done_idx,
                        output logic [7:0] mdr_done);
        busy_n = 0; done_n = 0; done_idx = -1; mdr_done = 8'h00;
        if (sel) begin
            ld_mar0 = 1'b1; ld_mdr0 = 1'b1; mem_rw0 = rw; addr0 = a; wdata0 = wd;
        end else begin
            ld_mar = 1'b1; ld_mdr = 1'b1; mem_rw = rw; addr = a; wdata = wd;
        end
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b0; ld_mar0 = 1'b0; ld_mdr0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (sel ? busy0 : busy) busy_n++;
            if (sel ? done0 : done) begin
                done_n++;
                if (done_idx < 0) done_idx = k;
                mdr_done = sel ? mdr0 : mdr;
            end
            tick();
        end
    endtask

    int         bn, dn, di, dcount;
    logic [7:0] md;

    initial begin
        // Reset state
        tick(); tick();
        check_val("rst_mar",  mar,  0);
        check_val("rst_mdr",  mdr,  0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err",  err,  0);
        rst_n = 1'b1;
        tick();

        // Write 0xA5 to 0x10
        xfer(0, 1'b1, 8'h10, 8'hA5, bn, dn, di, md);
        check_val("w10_busy_cycles", bn, 3);
        check_val("w10_done_idx",    di, 2);
        check_val("w10_done_cnt",    dn, 1);
        check_val("w10_mdr",         md, 8'hA5);
        check_val("w10_err",         err, 0);
        check_val("w10_mar",         mar, 8'h10);

        // Top and bottom addresses
        xfer(0, 1'b1, 8'hFF, 8'h3C, bn, dn, di, md);
        check_val("wff_done_cnt", dn, 1);
        xfer(0, 1'b1, 8'h00, 8'h00, bn, dn, di, md);
        check_val("w00_done_cnt", dn, 1);
        check_val("w00_mdr",      mdr, 8'h00);
        xfer(0, 1'b0, 8'hFF, 8'h00, bn, dn, di, md);
        check_val("rff_done_cnt", dn, 1);
        check_val("rff_mdr",      md, 8'h3C);

        // Same-cycle MAR load and read
        xfer(0, 1'b1, 8'h22, 8'h77, bn, dn, di, md);
        ld_mar = 1'b1; addr = 8'h05;
        tick();
        ld_mar = 1'b0;
        check_val("mar_05", mar, 8'h05);
        xfer(0, 1'b0, 8'h22, 8'h00, bn, dn, di, md);
        check_val("r22_mdr", md, 8'h77);
        check_val("r22_mar", mar, 8'h22);

        // Read through MAR only (no same-cycle load)
        ld_mar = 1'b1; addr = 8'hFF;
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b1; mem_rw = 1'b0; addr = 8'h22;
        tick();
        ld_mdr = 1'b0;
        tick(); tick();
        check_val("rmar_mdr",  mdr,  8'h3C);
        check_val("rmar_done", done, 1);
        tick();

        // Strobes during S_WAIT of a read from 0x10
        ld_mar = 1'b1; ld_mdr = 1'b1; mem_rw = 1'b0; addr = 8'h10;
        tick();
        dcount = done ? 1 : 0;
        ld_mar = 1'b1; ld_mdr = 1'b1; mem_rw = 1'b1; addr = 8'h40; wdata = 8'hEE;
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b0;
        check_val("wait_err_set", err, 1);
        check_val("wait_mar_kept", mar, 8'h10);
        md = 8'h00;
        for (int k = 0; k < 5; k++) begin
            if (done) begin
                dcount++;
                md = mdr;
            end
            tick();
        end
        check_val("wait_done_cnt", dcount, 1);
        check_val("wait_rd_mdr",   md, 8'hA5);
        check_val("wait_err_sticky", err, 1);

        // Reset in S_WAIT of a write
        xfer(0, 1'b1, 8'h08, 8'h11, bn, dn, di, md);
        ld_mar = 1'b1; ld_mdr = 1'b1; mem_rw = 1'b1; addr = 8'h08; wdata = 8'h99;
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_mar",  mar,  0);
        check_val("arst_mdr",  mdr,  0);
        check_val("arst_err",  err,  0);
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dcount++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dcount++;
        end
        check_val("arst_no_done", dcount, 0);
        xfer(0, 1'b0, 8'h08, 8'h00, bn, dn, di, md);
        check_val("arst_mem_kept", md, 8'h11);

        // Zero-wait instance
        xfer(1, 1'b1, 8'h01, 8'h5A, bn, dn, di, md);
        check_val("z_w_busy_cycles", bn, 1);
        check_val("z_w_done_idx",    di, 0);
        check_val("z_w_mdr",         md, 8'h5A);
        xfer(1, 1'b1, 8'h02, 8'hC3, bn, dn, di, md);
        xfer(1, 1'b0, 8'h01, 8'h00, bn, dn, di, md);
        check_val("z_r_busy_cycles", bn, 1);
        check_val("z_r_done_idx",    di, 0);
        check_val("z_r_done_cnt",    dn, 1);
        check_val("z_r_mdr",         md, 8'h5A);
        check_val("z_err",           err0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
